// File: rtl/carry_chain_pipe_if.sv
// Operand/result handshake bundle for carry_chain_pipe.
// master drives operands and out_ready; slave is the pipeline itself.
interface carry_chain_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic             ci;
  logic             cin_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
    output in_valid, p, g, ci, cin_sel, out_ready,
    input  in_ready, out_valid, s, co, ovf
  );

  modport slave (
    input  in_valid, p, g, ci, cin_sel, out_ready,
    output in_ready, out_valid, s, co, ovf
  );
endinterface

// File: rtl/carry_chain_pipe.sv
// Pipelined P/G ripple carry chain. WIDTH bits are split into
// STAGES = WIDTH/STAGE_W segments; each pipeline stage ripples one
// STAGE_W-bit slice and registers the partial result. The last stage
// register is the output register. cy_q holds the carry-out of the most
// recent beat to reach the output, for multi-word chaining.
module carry_chain_pipe #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned STAGE_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  carry_chain_pipe_if.slave bus
);
  localparam int unsigned STAGES = WIDTH / STAGE_W;
  localparam int unsigned IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if ((STAGE_W == 0) || ((WIDTH % STAGE_W) != 0)) begin : g_width_check
    $error("carry_chain_pipe: WIDTH must be a non-zero multiple of STAGE_W");
  end

  // Per-stage registers: valid, sums so far, p/g operands, running carry,
  // and carry into the most recently processed bit (gives c[WIDTH-1]).
  logic             vld_q  [STAGES];
  logic [WIDTH-1:0] sum_q  [STAGES];
  logic [WIDTH-1:0] p_q    [STAGES];
  logic [WIDTH-1:0] g_q    [STAGES];
  logic             cry_q  [STAGES];
  logic             cmsb_q [STAGES];

  logic             vld_nxt  [STAGES];
  logic [WIDTH-1:0] sum_nxt  [STAGES];
  logic [WIDTH-1:0] p_nxt    [STAGES];
  logic [WIDTH-1:0] g_nxt    [STAGES];
  logic             cry_nxt  [STAGES];
  logic             cmsb_nxt [STAGES];

  logic cy_q;
  logic stall;
  logic busy;
  logic ready_c;
  logic accept;

  // Any beat still in flight ahead of the output register blocks chained beats.
  always_comb begin
    busy = 1'b0;
    for (int unsigned k = 0; k + 1 < STAGES; k++) begin
      busy = busy | vld_q[k];
    end
  end

  assign stall        = vld_q[STAGES-1] & ~bus.out_ready;
  assign ready_c      = rst_n & ~stall & (~bus.cin_sel | ~busy);
  assign accept       = bus.in_valid & ready_c;
  assign bus.in_ready = ready_c;

  // Each stage ripples its own slice from the previous stage's register
  // (stage 0 takes the live operands and the selected carry-in).
  always_comb begin
    logic             v;
    logic             c;
    logic             cm;
    logic [WIDTH-1:0] sm;
    logic [WIDTH-1:0] pp;
    logic [WIDTH-1:0] gg;
    logic [IDX_W-1:0] idx;
    int unsigned      src;
    v   = 1'b0;
    c   = 1'b0;
    cm  = 1'b0;
    sm  = '0;
    pp  = '0;
    gg  = '0;
    idx = '0;
    src = 0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      src = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        v  = accept;
        sm = '0;
        pp = bus.p;
        gg = bus.g;
        c  = bus.cin_sel ? cy_q : bus.ci;
      end else begin
        v  = vld_q[src];
        sm = sum_q[src];
        pp = p_q[src];
        gg = g_q[src];
        c  = cry_q[src];
      end
      cm = 1'b0;
      for (int unsigned b = 0; b < STAGE_W; b++) begin
        idx     = IDX_W'(k * STAGE_W + b);
        cm      = c;
        sm[idx] = pp[idx] ^ c;
        c       = pp[idx] ? c : gg[idx];
      end
      vld_nxt[k]  = v;
      sum_nxt[k]  = sm;
      p_nxt[k]    = pp;
      g_nxt[k]    = gg;
      cry_nxt[k]  = c;
      cmsb_nxt[k] = cm;
    end
  end

  // Advance the whole pipeline unless the output is stalled; data only
  // loads alongside a valid beat so the output holds its last result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cy_q <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        vld_q[k]  <= 1'b0;
        sum_q[k]  <= '0;
        p_q[k]    <= '0;
        g_q[k]    <= '0;
        cry_q[k]  <= 1'b0;
        cmsb_q[k] <= 1'b0;
      end
    end else if (!stall) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_nxt[k];
        if (vld_nxt[k]) begin
          sum_q[k]  <= sum_nxt[k];
          p_q[k]    <= p_nxt[k];
          g_q[k]    <= g_nxt[k];
          cry_q[k]  <= cry_nxt[k];
          cmsb_q[k] <= cmsb_nxt[k];
        end
      end
      if (vld_nxt[STAGES-1]) begin
        cy_q <= cry_nxt[STAGES-1];
      end
    end
  end

  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.s         = sum_q[STAGES-1];
  assign bus.co        = cry_q[STAGES-1];
  assign bus.ovf       = cry_q[STAGES-1] ^ cmsb_q[STAGES-1];
endmodule
